// File: rtl/stencil_pkg.sv
// Shared state type and default geometry for the stencil window shifter.
package stencil_pkg;

   typedef enum logic {
      FILL   = 1'b0,
      STREAM = 1'b1
   } win_state_t;

   localparam int unsigned DEF_COL_H      = 5;
   localparam int unsigned DEF_PIX_W      = 1;
   localparam int unsigned DEF_WIN_W      = 3;
   localparam int unsigned DEF_IMG_COLS   = 16;
   localparam int unsigned DEF_FIFO_DEPTH = 2;

   localparam int unsigned COL_BITS = DEF_COL_H * DEF_PIX_W;
   localparam int unsigned WIN_BITS = DEF_WIN_W * COL_BITS;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stencil_win_fifo.sv
// Generic valid/ready FIFO (power-of-2 depth) holding {last, window} entries; no bypass.
module stencil_win_fifo
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 2
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] r_mem;
   logic [AW:0]                 r_wr_ptr;
   logic [AW:0]                 r_rd_ptr;
   logic                        w_do_push;
   logic                        w_do_pop;

   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
            r_wr_ptr                <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   // Extra wrap bit on each pointer separates full from empty.
   assign empty    = (r_wr_ptr == r_rd_ptr);
   assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign pop_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/stencil_window_shifter.sv
// Sliding COL_H x WIN_W column window per image row, emitted through a valid/ready FIFO.
// Optional win_count/drop_count statistics when STENCIL_WIN_STATS_EN is defined.
module stencil_window_shifter
   import stencil_pkg::*;
#(
   parameter int unsigned COL_H      = DEF_COL_H,
   parameter int unsigned PIX_W      = DEF_PIX_W,
   parameter int unsigned WIN_W      = DEF_WIN_W,
   parameter int unsigned IMG_COLS   = DEF_IMG_COLS,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [COL_H*PIX_W-1:0]         col_pixels,
   input  logic                           col_valid,
   output logic [WIN_W*COL_H*PIX_W-1:0]   win_data,
   output logic                           win_last,
   output logic                           win_valid,
   input  logic                           win_ready,
   output logic                           overflow,
`ifdef STENCIL_WIN_STATS_EN
   output logic [15:0]                    win_count,
   output logic [15:0]                    drop_count,
`endif
   input  logic                           clr_overflow
);

   localparam int unsigned L_COL_BITS = COL_H * PIX_W;
   localparam int unsigned L_WIN_BITS = WIN_W * L_COL_BITS;
   localparam int unsigned CNT_W      = cnt_width(IMG_COLS);
   // A one-column window never needs priming, so it lives in STREAM permanently.
   localparam win_state_t RST_STATE   = (WIN_W == 1) ? STREAM : FILL;

   logic [WIN_W-1:0][L_COL_BITS-1:0] r_shift;
   logic [WIN_W-1:0][L_COL_BITS-1:0] w_shift_nxt;
   logic [CNT_W-1:0]                 r_col_cnt;
   win_state_t                       r_state;
   win_state_t                       w_state_nxt;
   logic                             w_produce;
   logic                             w_last_col;
   logic                             w_fill_done;
   logic                             w_push;
   logic                             w_pop;
   logic                             w_drop;
   logic                             w_full;
   logic                             w_empty;
   logic [L_WIN_BITS:0]              w_head;
   logic                             r_overflow;

   generate
      if (WIN_W == 1) begin : g_single
         assign w_shift_nxt = col_pixels;
      end else begin : g_multi
         assign w_shift_nxt = {col_pixels, r_shift[WIN_W-1:1]};
      end
   endgenerate

   assign w_last_col  = (r_col_cnt == CNT_W'(IMG_COLS - 1));
   assign w_fill_done = (WIN_W >= 2) && (r_col_cnt == CNT_W'(WIN_W - 2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift   <= '0;
         r_col_cnt <= '0;
         r_state   <= RST_STATE;
      end else begin
         r_state <= w_state_nxt;
         if (col_valid) begin
            r_shift   <= w_shift_nxt;
            r_col_cnt <= w_last_col ? '0 : r_col_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_produce   = 1'b0;
      unique case (r_state)
         FILL: begin
            if (col_valid && w_fill_done) w_state_nxt = STREAM;
         end
         STREAM: begin
            w_produce = col_valid;
            if (col_valid && w_last_col && (WIN_W != 1)) w_state_nxt = FILL;
         end
         default: w_state_nxt = RST_STATE;
      endcase
   end

   assign w_pop  = win_valid & win_ready;
   assign w_push = w_produce & (~w_full | w_pop);
   assign w_drop = w_produce & w_full & ~w_pop;

   stencil_win_fifo #(
      .WIDTH (L_WIN_BITS + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data ({w_last_col, w_shift_nxt}),
      .pop       (w_pop),
      .pop_data  (w_head),
      .full      (w_full),
      .empty     (w_empty)
   );

   assign {win_last, win_data} = w_head;
   assign win_valid            = ~w_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_overflow) begin
         r_overflow <= 1'b0;
      end
   end

   assign overflow = r_overflow;

`ifdef STENCIL_WIN_STATS_EN
   logic [15:0] r_win_count;
   logic [15:0] r_drop_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win_count  <= '0;
         r_drop_count <= '0;
      end else if (clr_overflow) begin
         r_win_count  <= '0;
         r_drop_count <= '0;
      end else begin
         if (w_push && (r_win_count != '1))  r_win_count  <= r_win_count + 1'b1;
         if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + 1'b1;
      end
   end

   assign win_count  = r_win_count;
   assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_stencil_window_shifter.sv
// Scoreboard bench for stencil_window_shifter: row-indexed reference model plus handshake monitor.
module tb_stencil_window_shifter;

   localparam int unsigned COL_H      = 5;
   localparam int unsigned PIX_W      = 1;
   localparam int unsigned WIN_W      = 3;
   localparam int unsigned IMG_COLS   = 16;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned CB         = COL_H * PIX_W;
   localparam int unsigned WB         = WIN_W * CB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CB-1:0] col_pixels = '0;
   logic          col_valid = 1'b0;
   logic [WB-1:0] win_data;
   logic          win_last;
   logic          win_valid;
   logic          win_ready = 1'b0;
   logic          overflow;
   logic          clr_overflow = 1'b0;
`ifdef STENCIL_WIN_STATS_EN
   logic [15:0]   win_count;
   logic [15:0]   drop_count;
`endif

   typedef struct packed {
      logic          last;
      logic [WB-1:0] data;
   } win_t;

   win_t          sb_q[$];
   logic [CB-1:0] m_row [IMG_COLS];
   int unsigned   m_occ = 0;
   int unsigned   m_pos = 0;
   int unsigned   m_wcnt = 0;
   int unsigned   m_dcnt = 0;
   logic          m_ovf = 1'b0;
   bit            m_pop, m_produce, m_dropped;
   win_t          m_w;

   int unsigned   checks = 0;
   int unsigned   failures = 0;
   int unsigned   n_taken = 0;
   win_t          first_taken, last_taken;

   always #5 clk = ~clk;

   stencil_window_shifter #(
      .COL_H      (COL_H),
      .PIX_W      (PIX_W),
      .WIN_W      (WIN_W),
      .IMG_COLS   (IMG_COLS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .col_pixels   (col_pixels),
      .col_valid    (col_valid),
      .win_data     (win_data),
      .win_last     (win_last),
      .win_valid    (win_valid),
      .win_ready    (win_ready),
      .overflow     (overflow),
`ifdef STENCIL_WIN_STATS_EN
      .win_count    (win_count),
      .drop_count   (drop_count),
`endif
      .clr_overflow (clr_overflow)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: windows are the last WIN_W columns of the current row, by row position.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_q.delete();
         m_occ  = 0;
         m_pos  = 0;
         m_ovf  = 1'b0;
         m_wcnt = 0;
         m_dcnt = 0;
      end else begin
         m_pop     = (m_occ != 0) && win_ready;
         m_produce = 1'b0;
         m_dropped = 1'b0;
         if (col_valid) begin
            m_row[m_pos] = col_pixels;
            if (m_pos + 1 >= WIN_W) begin
               m_produce = 1'b1;
               for (int c = 0; c < int'(WIN_W); c++)
                  m_w.data[c*CB +: CB] = m_row[m_pos - WIN_W + 1 + c];
               m_w.last = (m_pos == IMG_COLS - 1);
            end
            m_pos = (m_pos + 1) % IMG_COLS;
         end
         if (m_pop) m_occ--;
         if (m_produce) begin
            if (m_occ < FIFO_DEPTH) begin
               sb_q.push_back(m_w);
               m_occ++;
            end else begin
               m_dropped = 1'b1;
            end
         end
         if (m_dropped) m_ovf = 1'b1;
         else if (clr_overflow) m_ovf = 1'b0;
         if (clr_overflow) begin
            m_wcnt = 0;
            m_dcnt = 0;
         end else begin
            if (m_produce && !m_dropped && m_wcnt < 16'hFFFF) m_wcnt++;
            if (m_dropped && m_dcnt < 16'hFFFF) m_dcnt++;
         end
      end
   end

   // Monitor: compares the FIFO head against the scoreboard, pops on handshake.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst_n) begin
            chk("win_valid", win_valid, (m_occ != 0));
            chk("overflow", overflow, m_ovf);
`ifdef STENCIL_WIN_STATS_EN
            chk("win_count", win_count, m_wcnt);
            chk("drop_count", drop_count, m_dcnt);
`endif
            if (win_valid) begin
               if (sb_q.size() == 0) begin
                  chk("sb_underrun", 1, 0);
               end else begin
                  chk("win_data", win_data, sb_q[0].data);
                  chk("win_last", win_last, sb_q[0].last);
                  if (win_ready) void'(sb_q.pop_front());
               end
               if (win_ready) begin
                  n_taken++;
                  last_taken = {win_last, win_data};
                  if (n_taken == 1) first_taken = {win_last, win_data};
               end
            end
         end
      end
   end

   task automatic cyc(input logic v, input logic [CB-1:0] p, input logic rdy, input logic clr);
      @(negedge clk);
      col_valid    = v;
      col_pixels   = p;
      win_ready    = rdy;
      clr_overflow = clr;
   endtask

   int unsigned base;

   initial begin
      // Reset
      repeat (3) @(negedge clk);
      #1;
      chk("rst_valid", win_valid, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_data", win_data, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill and stream one row
      base = n_taken;
      for (int i = 0; i < 16; i++) cyc(1'b1, CB'(i), 1'b1, 1'b0);
      repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("row_windows", n_taken - base, 14);
      chk("first_window", first_taken, {1'b0, 15'h0820});
      chk("last_window", last_taken, {1'b1, 15'h3DCD});

      // Two back-to-back rows with random pixels
      base = n_taken;
      for (int i = 0; i < 32; i++) cyc(1'b1, CB'($urandom), 1'b1, 1'b0);
      repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("two_row_windows", n_taken - base, 28);

      // Backpressure: two held, twelve dropped
      cyc(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) cyc(1'b1, CB'(i), 1'b0, 1'b0);
      repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("bp_overflow", overflow, 1);
      chk("bp_valid", win_valid, 1);
      chk("bp_held", win_data, 15'h0820);
`ifdef STENCIL_WIN_STATS_EN
      chk("bp_win_count", win_count, 2);
      chk("bp_drop_count", drop_count, 12);
`endif
      base = n_taken;
      repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("bp_drained", n_taken - base, 2);
      chk("bp_second", last_taken, {1'b0, 15'h0C41});
      cyc(1'b0, '0, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("clr_overflow", overflow, 0);
`ifdef STENCIL_WIN_STATS_EN
      chk("clr_win_count", win_count, 0);
      chk("clr_drop_count", drop_count, 0);
`endif

      // Full FIFO with same-cycle pop and push
      for (int i = 0; i < 4; i++) cyc(1'b1, CB'(i), 1'b0, 1'b0);
      cyc(1'b1, CB'(4), 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("fullpop_overflow", overflow, 0);
      chk("fullpop_head", win_data, 15'h0C41);
      for (int i = 5; i < 16; i++) cyc(1'b1, CB'(i), 1'b1, 1'b0);
      repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);

      // Mid-row reset with a full FIFO and a pending drop
      for (int i = 0; i < 5; i++) cyc(1'b1, CB'(i), 1'b0, 1'b0);
      @(negedge clk);
      col_valid = 1'b0;
      rst_n     = 1'b0;
      #1;
      chk("midrst_valid", win_valid, 0);
      chk("midrst_overflow", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            @(negedge clk);
            rst_n = 1'b0;
            col_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            cyc(($urandom_range(0, 3) != 0), CB'($urandom),
                ($urandom_range(0, (i / 500) % 3 + 1) != 0),
                ($urandom_range(0, 15) == 0));
         end
      end
      repeat (6) cyc(1'b0, '0, 1'b1, 1'b0);
      #1;
      chk("final_drain", sb_q.size(), 0);
      chk("final_valid", win_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
